// File: rtl/reg_bank_8x32.sv
// Eight-entry register bank with a priority write-back port and a queued secondary load port.
// Queued loads drain on idle write-back cycles; newer write-backs cancel older queued loads.
module reg_bank_8x32 #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned QDEPTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wb_we,
  input  logic [2:0]                     wb_addr,
  input  logic [WIDTH-1:0]               wb_data,
  input  logic                           ld_valid,
  output logic                           ld_ready,
  input  logic [2:0]                     ld_addr,
  input  logic [WIDTH-1:0]               ld_data,
  output logic [WIDTH-1:0]               R1,
  output logic [WIDTH-1:0]               R2,
  output logic [WIDTH-1:0]               R3,
  output logic [WIDTH-1:0]               R4,
  output logic [WIDTH-1:0]               R5,
  output logic [WIDTH-1:0]               R6,
  output logic [WIDTH-1:0]               R7,
  output logic [WIDTH-1:0]               R8,
  output logic [7:0]                     busy,
  output logic [$clog2(QDEPTH+1)-1:0]    q_count
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QdMax = CW'(QDEPTH);

  logic [WIDTH-1:0]  regs_q [8];
  logic [2:0]        addr_q [QDEPTH];
  logic [WIDTH-1:0]  data_q [QDEPTH];
  logic [QDEPTH-1:0] live_q, live_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop, drain_wr;

  assign ld_ready = (count_q < QdMax);
  assign push     = ld_valid & ld_ready;
  assign pop      = ~wb_we & (count_q != '0);
  assign drain_wr = pop & live_q[head_q];

  always_comb begin
    live_d = live_q;
    // Kill applies to entries already queued; the same-cycle push below is younger.
    for (int i = 0; i < QDEPTH; i++) begin
      if (wb_we && (addr_q[i] == wb_addr)) live_d[i] = 1'b0;
    end
    if (pop)  live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = 1'b1;
    head_d  = pop  ? head_q + 1'b1 : head_q;
    tail_d  = push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (live_q[i]) busy[addr_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      live_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (wb_we) begin
        regs_q[wb_addr] <= wb_data;
      end else if (drain_wr) begin
        regs_q[addr_q[head_q]] <= data_q[head_q];
      end
      if (push) begin
        addr_q[tail_q] <= ld_addr;
        data_q[tail_q] <= ld_data;
      end
      live_q  <= live_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign q_count = count_q;
  assign R1 = regs_q[0];
  assign R2 = regs_q[1];
  assign R3 = regs_q[2];
  assign R4 = regs_q[3];
  assign R5 = regs_q[4];
  assign R6 = regs_q[5];
  assign R7 = regs_q[6];
  assign R8 = regs_q[7];

endmodule

// File: tb/tb_reg_bank_8x32.sv
// Directed bench for reg_bank_8x32: per-cycle vector table plus hand-written
// reset sequences, each vector checked one edge after it is applied.
module tb_reg_bank_8x32;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] R1, R2, R3, R4, R5, R6, R7, R8;
  logic [7:0]  busy;
  logic [1:0]  q_count;
  logic [31:0] r_out [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_bank_8x32 #(.WIDTH(32), .QDEPTH(2)) dut (
    .clk(clk), .reset(reset), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7), .R8(R8),
    .busy(busy), .q_count(q_count)
  );

  assign r_out[0] = R1;
  assign r_out[1] = R2;
  assign r_out[2] = R3;
  assign r_out[3] = R4;
  assign r_out[4] = R5;
  assign r_out[5] = R6;
  assign r_out[6] = R7;
  assign r_out[7] = R8;

  typedef struct packed {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        lv;
    logic [2:0]  la;
    logic [31:0] ldat;
    logic [2:0]  ri;    // register index checked after the edge
    logic [31:0] er;
    logic [1:0]  ec;
    logic [7:0]  eb;
    logic        erdy;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_R%0d", tag, i + 1), r_out[i], 32'h0);
    chk({tag, "_count"}, 32'(q_count), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_ready"}, 32'(ld_ready), 32'h1);
  endtask

  initial begin
    //            we wa  wd            lv la  ldat          ri  er            ec    eb     rdy
    vt[0]  = '{1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'h0,  3'd3, 32'hDEADBEEF, 2'd0, 8'h00, 1'b1};
    vt[1]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd0, 32'h0,        2'd0, 8'h00, 1'b1};
    vt[2]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd0, 32'h11, 3'd0, 32'h0,        2'd1, 8'h01, 1'b1};
    vt[3]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd0, 32'h11,       2'd0, 8'h00, 1'b1};
    vt[4]  = '{1'b1, 3'd7, 32'h77,       1'b1, 3'd1, 32'h22, 3'd7, 32'h77,       2'd1, 8'h02, 1'b1};
    vt[5]  = '{1'b1, 3'd7, 32'h78,       1'b1, 3'd2, 32'h33, 3'd7, 32'h78,       2'd2, 8'h06, 1'b0};
    vt[6]  = '{1'b1, 3'd7, 32'h79,       1'b1, 3'd3, 32'h44, 3'd7, 32'h79,       2'd2, 8'h06, 1'b0};
    vt[7]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd1, 32'h22,       2'd1, 8'h04, 1'b1};
    vt[8]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd2, 32'h33,       2'd0, 8'h00, 1'b1};
    vt[9]  = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd3, 32'hDEADBEEF, 2'd0, 8'h00, 1'b1};
    vt[10] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd5, 32'hAA, 3'd5, 32'h0,        2'd1, 8'h20, 1'b1};
    vt[11] = '{1'b1, 3'd5, 32'hBB,       1'b0, 3'd0, 32'h0,  3'd5, 32'hBB,       2'd1, 8'h00, 1'b1};
    vt[12] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd5, 32'hBB,       2'd0, 8'h00, 1'b1};
    vt[13] = '{1'b1, 3'd2, 32'h1,        1'b1, 3'd2, 32'h55, 3'd2, 32'h1,        2'd1, 8'h04, 1'b1};
    vt[14] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd2, 32'h55,       2'd0, 8'h00, 1'b1};
    vt[15] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd6, 32'h66, 3'd6, 32'h0,        2'd1, 8'h40, 1'b1};
    vt[16] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd4, 32'h99, 3'd6, 32'h66,       2'd1, 8'h10, 1'b1};
    vt[17] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd4, 32'h99,       2'd0, 8'h00, 1'b1};
    vt[18] = '{1'b1, 3'd0, 32'h10,       1'b1, 3'd1, 32'hA1, 3'd0, 32'h10,       2'd1, 8'h02, 1'b1};
    vt[19] = '{1'b1, 3'd0, 32'h10,       1'b1, 3'd2, 32'hA2, 3'd0, 32'h10,       2'd2, 8'h06, 1'b0};
    vt[20] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd3, 32'hA3, 3'd1, 32'hA1,       2'd1, 8'h04, 1'b1};
    vt[21] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd2, 32'hA2,       2'd0, 8'h00, 1'b1};
    vt[22] = '{1'b0, 3'd0, 32'h0,        1'b0, 3'd0, 32'h0,  3'd3, 32'hDEADBEEF, 2'd0, 8'h00, 1'b1};

    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      wb_we = vt[i].we; wb_addr = vt[i].wa; wb_data = vt[i].wd;
      ld_valid = vt[i].lv; ld_addr = vt[i].la; ld_data = vt[i].ldat;
      @(negedge clk);
      chk($sformatf("v%0d_R%0d", i, vt[i].ri + 1), r_out[vt[i].ri], vt[i].er);
      chk($sformatf("v%0d_count", i), 32'(q_count), 32'(vt[i].ec));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].eb));
      chk($sformatf("v%0d_ready", i), 32'(ld_ready), 32'(vt[i].erdy));
    end

    // Full queue with wb_we released: ld_ready must stay low in the popping cycle.
    wb_we = 1'b1; wb_addr = 3'd7; wb_data = 32'h5;
    ld_valid = 1'b1; ld_addr = 3'd0; ld_data = 32'hE0;
    @(negedge clk);
    ld_addr = 3'd1; ld_data = 32'hE1;
    @(negedge clk);
    wb_we = 1'b0; ld_addr = 3'd4; ld_data = 32'hE4;
    #1;
    chk("full_pop_ready", 32'(ld_ready), 32'h0);
    chk("full_pop_count", 32'(q_count), 32'h2);
    chk("full_busy", 32'(busy), 32'h03);

    // Async reset mid-drain with two entries queued.
    reset = 1'b1;
    ld_valid = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
